// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Shared types and constants for the I2S receive path (i2s_in) and its FIFO.
//   DATA_W     : sample width per channel
//   CNT_W      : width of the per-slot bit counter (counts 0..DATA_W)
//   WS_LEFT / WS_RIGHT : word-select encoding
//   state_e    : receive FSM states
//   pair_t     : one stereo pair {lft, rgt}, lft in the upper half
//   justify()  : left-aligns a partially filled shift register
// ---------------------------------------------------------------------------
package i2s_pkg;

   localparam int   DATA_W   = 16;
   localparam int   CNT_W    = $clog2(DATA_W + 1);
   localparam logic WS_LEFT  = 1'b0;
   localparam logic WS_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2
   } state_e;

   typedef struct packed {
      logic [DATA_W-1:0] lft;
      logic [DATA_W-1:0] rgt;
   } pair_t;

   // Short slots arrive MSB first, so the captured bits sit in the low end of
   // the shift register; move them up and zero-pad the bottom.
   function automatic logic [DATA_W-1:0] justify(input logic [DATA_W-1:0] shreg,
                                                 input logic [CNT_W-1:0]  cnt);
      logic [DATA_W-1:0] res;
      if (cnt == '0) begin
         res = '0;
      end else if (cnt >= CNT_W'(DATA_W)) begin
         res = shreg;
      end else begin
         res = shreg << (CNT_W'(DATA_W) - cnt);
      end
      return res;
   endfunction

endpackage

// File: rtl/i2s_fifo.sv
// ---------------------------------------------------------------------------
// i2s_fifo
// Synchronous first-word-fall-through FIFO; the head entry is visible on
// o_head whenever o_empty is low. A push into a full FIFO is accepted only
// when a pop happens in the same cycle; otherwise it is ignored.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_push        : write request, i_push_data the entry
//   i_pop         : remove the head entry (ignored when empty)
//   o_head        : head entry (stale when empty)
//   o_full/o_empty: occupancy flags
// DEPTH must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module i2s_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   // Pointers carry one extra wrap bit to tell full from empty.
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
      end
   end

endmodule

// File: rtl/i2s_in.sv
// ---------------------------------------------------------------------------
// i2s_in
// Slave-mode I2S receiver. SCK, WS and SD are oversampled on i_clk, 16-bit
// stereo pairs are deserialised and queued in a FWFT FIFO, and presented on a
// ready-to-send / ready-to-receive handshake.
//   i_clk          : system clock (only clock)
//   i_rst          : synchronous active-high reset
//   i_sck/i_ws/i_sd: external bit clock, word select (0=left), data MSB first
//   o_din_lft/rgt  : pair at the FIFO head (hold last value when empty)
//   o_din_rts      : FIFO holds a pair
//   i_din_rtr      : downstream accepts the head this cycle
//   o_fifo_overun  : sticky, a pair was dropped on a full FIFO
// Build option: define I2S_IN_LJ_EN for left-justified framing (the bit on a
// WS change is the new channel's MSB); default is standard I2S with the
// one-bit delay.
//
// state | meaning
// ------+------------------------------------------------------------
// SYNC  | discarding bits until a 1->0 WS change marks a left slot
// LEFT  | shifting left-channel bits; 0->1 WS change finalises left
// RIGHT | shifting right-channel bits; 1->0 WS change pushes the pair
// ---------------------------------------------------------------------------
module i2s_in
   import i2s_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_sck,
   input  logic              i_ws,
   input  logic              i_sd,
   output logic [DATA_W-1:0] o_din_lft,
   output logic [DATA_W-1:0] o_din_rgt,
   output logic              o_din_rts,
   input  logic              i_din_rtr,
   output logic              o_fifo_overun
);

   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_ws_sync;
   logic [SYNC_STAGES-1:0] r_sd_sync;
   logic                   r_sck_d;
   logic                   r_ws_prev;

   logic w_sck_s;
   logic w_ws_s;
   logic w_sd_s;
   logic w_bit_edge;
   logic w_ws_chg;
   logic w_ws_fall;
   logic w_ws_rise;

   state_e r_state;
   state_e w_state_nxt;

   logic w_take;
   logic w_restart;
   logic w_fin_lft;
   logic w_push;

   logic [CNT_W-1:0]  r_bit_cnt;
   logic [CNT_W-1:0]  w_cnt_shift;
   logic [CNT_W-1:0]  w_cnt_restart;
   logic [DATA_W-1:0] r_shreg;
   logic [DATA_W-1:0] w_shreg_shift;
   logic [DATA_W-1:0] w_shreg_restart;
   logic [DATA_W-1:0] w_word;
   logic [DATA_W-1:0] r_lft_hold;

   pair_t             w_push_pair;
   pair_t             w_head_pair;
   pair_t             w_out_pair;
   pair_t             r_last;
   logic [2*DATA_W-1:0] w_head;
   logic              w_full;
   logic              w_empty;
   logic              w_pop;
   logic              r_overun;

   // ------------------------------------------------------------------
   // Input synchronisers and SCK rise detect
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sck_sync <= '0;
         r_ws_sync  <= '0;
         r_sd_sync  <= '0;
         r_sck_d    <= 1'b0;
         r_ws_prev  <= WS_LEFT;
      end else begin
         r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
         r_ws_sync  <= {r_ws_sync[SYNC_STAGES-2:0], i_ws};
         r_sd_sync  <= {r_sd_sync[SYNC_STAGES-2:0], i_sd};
         r_sck_d    <= w_sck_s;
         if (w_bit_edge) begin
            r_ws_prev <= w_ws_s;
         end
      end
   end

   assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
   assign w_ws_s     = r_ws_sync[SYNC_STAGES-1];
   assign w_sd_s     = r_sd_sync[SYNC_STAGES-1];
   assign w_bit_edge = w_sck_s && !r_sck_d;
   assign w_ws_chg   = (w_ws_s != r_ws_prev);
   assign w_ws_fall  = w_ws_chg && (w_ws_s == WS_LEFT);
   assign w_ws_rise  = w_ws_chg && (w_ws_s == WS_RIGHT);

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= SYNC;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      if (w_bit_edge) begin
         case (r_state)
            SYNC:    if (w_ws_fall) w_state_nxt = LEFT;
            LEFT:    if (w_ws_rise) w_state_nxt = RIGHT;
            RIGHT:   if (w_ws_fall) w_state_nxt = LEFT;
            default: w_state_nxt = SYNC;
         endcase
      end else if (r_state != SYNC && r_state != LEFT && r_state != RIGHT) begin
         w_state_nxt = SYNC;
      end
   end

   // ------------------------------------------------------------------
   // FSM: datapath controls
   // ------------------------------------------------------------------
   always_comb begin
      w_take    = 1'b0;
      w_restart = 1'b0;
      w_fin_lft = 1'b0;
      w_push    = 1'b0;
      if (w_bit_edge) begin
         case (r_state)
            SYNC: begin
               w_restart = w_ws_fall;
            end
            LEFT: begin
               w_fin_lft = w_ws_rise;
               w_restart = w_ws_rise;
               w_take    = !w_ws_rise;
            end
            RIGHT: begin
               w_push    = w_ws_fall;
               w_restart = w_ws_fall;
               w_take    = !w_ws_fall;
            end
            default: begin
               w_take = 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Bit capture. Bits past DATA_W are dropped so wide slots keep their
   // top DATA_W bits.
   // ------------------------------------------------------------------
   always_comb begin
      w_shreg_shift = r_shreg;
      w_cnt_shift   = r_bit_cnt;
      if (r_bit_cnt < CNT_W'(DATA_W)) begin
         w_shreg_shift = {r_shreg[DATA_W-2:0], w_sd_s};
         w_cnt_shift   = r_bit_cnt + 1'b1;
      end
`ifdef I2S_IN_LJ_EN
      // The change-edge bit already belongs to the new channel: finish the
      // old word without it, then start the new word with it.
      w_word          = justify(r_shreg, r_bit_cnt);
      w_shreg_restart = {{(DATA_W-1){1'b0}}, w_sd_s};
      w_cnt_restart   = CNT_W'(1);
`else
      // The change-edge bit is the LSB of the ending channel.
      w_word          = justify(w_shreg_shift, w_cnt_shift);
      w_shreg_restart = '0;
      w_cnt_restart   = '0;
`endif
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_bit_cnt  <= '0;
         r_shreg    <= '0;
         r_lft_hold <= '0;
      end else begin
         if (w_restart) begin
            r_bit_cnt <= w_cnt_restart;
            r_shreg   <= w_shreg_restart;
         end else if (w_take) begin
            r_bit_cnt <= w_cnt_shift;
            r_shreg   <= w_shreg_shift;
         end
         if (w_fin_lft) begin
            r_lft_hold <= w_word;
         end
      end
   end

   // ------------------------------------------------------------------
   // Pair FIFO and handshake
   // ------------------------------------------------------------------
   assign w_push_pair.lft = r_lft_hold;
   assign w_push_pair.rgt = w_word;

   i2s_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (2*DATA_W)
   ) u_fifo (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push      (w_push),
      .i_push_data (w_push_pair),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

   assign w_head_pair = w_head;
   assign w_pop       = !w_empty && i_din_rtr;

   // r_last tracks the head so the outputs hold the last shown pair once
   // the FIFO drains, instead of exposing stale storage.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_last   <= '0;
         r_overun <= 1'b0;
      end else begin
         if (!w_empty) begin
            r_last <= w_head_pair;
         end
         if (w_push && w_full && !w_pop) begin
            r_overun <= 1'b1;
         end
      end
   end

   assign w_out_pair    = w_empty ? r_last : w_head_pair;
   assign o_din_lft     = w_out_pair.lft;
   assign o_din_rgt     = w_out_pair.rgt;
   assign o_din_rts     = !w_empty;
   assign o_fifo_overun = r_overun;

endmodule

// File: tb/tb_i2s_in.sv
module tb_i2s_in;

   logic        clk;
   logic        rst;
   logic        sck;
   logic        ws;
   logic        sd;
   logic        din_rtr;
   logic [15:0] din_lft;
   logic [15:0] din_rgt;
   logic        din_rts;
   logic        fifo_overun;

   int          checks;
   int          errors;
   int          rts_cycles;
   logic        tb_pend;
   logic [31:0] q_pairs[$];

   i2s_in dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_sck         (sck),
      .i_ws          (ws),
      .i_sd          (sd),
      .o_din_lft     (din_lft),
      .o_din_rgt     (din_rgt),
      .o_din_rts     (din_rts),
      .i_din_rtr     (din_rtr),
      .o_fifo_overun (fifo_overun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Records every pair actually handed over (rts && rtr at a posedge).
   always @(negedge clk) begin
      if (din_rts === 1'b1) rts_cycles = rts_cycles + 1;
      if (din_rts === 1'b1 && din_rtr === 1'b1) q_pairs.push_back({din_lft, din_rgt});
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_rtr(input logic v);
      @(posedge clk);
      #1 din_rtr = v;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sck = 1'b0;
      ws  = 1'b0;
      sd  = 1'b0;
      tb_pend = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // One SCK period of 8 clk: data/ws change with the falling edge.
   task automatic send_bit(input logic ws_v, input logic sd_v);
      sck = 1'b0;
      ws  = ws_v;
      sd  = sd_v;
      repeat (4) @(negedge clk);
      sck = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_slot(input logic ws_v, input logic [31:0] word, input int w,
                            input int from, input int upto);
      for (int i = from; i < upto; i++) begin
`ifdef I2S_IN_LJ_EN
         send_bit(ws_v, word[w-1-i]);
`else
         send_bit(ws_v, tb_pend);
         tb_pend = word[w-1-i];
`endif
      end
   endtask

   task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int w);
      send_slot(1'b0, l, w, 0, w);
      send_slot(1'b1, r, w, 0, w);
   endtask

   // First edge of a following left slot: finalises the pending right word.
   task automatic close_frame();
      send_bit(1'b0, tb_pend);
      repeat (12) @(negedge clk);
   endtask

   task automatic preamble();
      send_slot(1'b1, 32'h0, 16, 0, 16);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      sck = 1'b0;
      ws  = 1'b0;
      sd  = 1'b0;
      din_rtr = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (din_lft !== 16'h0) begin errors++; $display("FAIL reset_lft got %h want 0000", din_lft); end
      checks++; if (din_rgt !== 16'h0) begin errors++; $display("FAIL reset_rgt got %h want 0000", din_rgt); end
      checks++; if (din_rts !== 1'b0) begin errors++; $display("FAIL reset_rts got %b want 0", din_rts); end
      checks++; if (fifo_overun !== 1'b0) begin errors++; $display("FAIL reset_overun got %b want 0", fifo_overun); end
   endtask

   task automatic test_basic();
      int q0;
      int c0;
      do_reset();
      set_rtr(1'b1);
      q0 = q_pairs.size();
      c0 = rts_cycles;
      preamble();
      for (int f = 0; f < 3; f++) send_frame(32'hA5C3, 32'h1234, 16);
      close_frame();
      checks++; if (q_pairs.size() - q0 !== 3) begin errors++; $display("FAIL basic_count got %0d want 3", q_pairs.size() - q0); end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (q0 + k >= q_pairs.size()) begin
            errors++; $display("FAIL basic_pair%0d got none want a5c31234", k);
         end else if (q_pairs[q0+k] !== 32'hA5C3_1234) begin
            errors++; $display("FAIL basic_pair%0d got %h want a5c31234", k, q_pairs[q0+k]);
         end
      end
      checks++; if (rts_cycles - c0 !== 3) begin errors++; $display("FAIL basic_rts_cycles got %0d want 3", rts_cycles - c0); end
      checks++; if (fifo_overun !== 1'b0) begin errors++; $display("FAIL basic_overun got %b want 0", fifo_overun); end
   endtask

   task automatic test_mid_slot();
      int q0;
      do_reset();
      set_rtr(1'b1);
      q0 = q_pairs.size();
      send_slot(1'b1, 32'hFFFF, 16, 8, 16);
      send_frame(32'h0001, 32'h8000, 16);
      close_frame();
      checks++; if (q_pairs.size() - q0 !== 1) begin errors++; $display("FAIL mid_count got %0d want 1", q_pairs.size() - q0); end
      checks++;
      if (q0 >= q_pairs.size()) begin
         errors++; $display("FAIL mid_pair got none want 00018000");
      end else if (q_pairs[q0] !== 32'h0001_8000) begin
         errors++; $display("FAIL mid_pair got %h want 00018000", q_pairs[q0]);
      end
   endtask

   task automatic test_widths();
      int q0;
      logic [31:0] exp_p [2];
      exp_p[0] = 32'h1234_ABCD;
      exp_p[1] = 32'hABC0_3210;
      do_reset();
      set_rtr(1'b1);
      q0 = q_pairs.size();
      preamble();
      send_frame(32'h1234_5600, 32'hABCD_EF00, 32);
      send_frame(32'h0000_0ABC, 32'h0000_0321, 12);
      close_frame();
      checks++; if (q_pairs.size() - q0 !== 2) begin errors++; $display("FAIL width_count got %0d want 2", q_pairs.size() - q0); end
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (q0 + k >= q_pairs.size()) begin
            errors++; $display("FAIL width_pair%0d got none want %h", k, exp_p[k]);
         end else if (q_pairs[q0+k] !== exp_p[k]) begin
            errors++; $display("FAIL width_pair%0d got %h want %h", k, q_pairs[q0+k], exp_p[k]);
         end
      end
   endtask

   task automatic test_overrun();
      int q0;
      logic [15:0] nn;
      do_reset();
      set_rtr(1'b0);
      preamble();
      for (int n = 1; n <= 5; n++) begin
         nn = 16'(n);
         send_frame({16'h0, nn}, {16'h0, ~nn}, 16);
         if (n == 1) begin
            checks++; if (din_rts !== 1'b0) begin errors++; $display("FAIL ovr_rts_before_close got %b want 0", din_rts); end
         end
         if (n == 2) begin
            checks++; if (din_rts !== 1'b1) begin errors++; $display("FAIL ovr_rts_after_f1 got %b want 1", din_rts); end
            checks++; if ({din_lft, din_rgt} !== 32'h0001_FFFE) begin errors++; $display("FAIL ovr_head_f1 got %h want 0001fffe", {din_lft, din_rgt}); end
         end
         if (n == 5) begin
            checks++; if (fifo_overun !== 1'b0) begin errors++; $display("FAIL ovr_full_no_flag got %b want 0", fifo_overun); end
         end
      end
      close_frame();
      checks++; if (fifo_overun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", fifo_overun); end
      checks++; if ({din_lft, din_rgt} !== 32'h0001_FFFE) begin errors++; $display("FAIL ovr_head_kept got %h want 0001fffe", {din_lft, din_rgt}); end
      q0 = q_pairs.size();
      set_rtr(1'b1);
      repeat (10) @(negedge clk);
      checks++; if (q_pairs.size() - q0 !== 4) begin errors++; $display("FAIL ovr_drain_count got %0d want 4", q_pairs.size() - q0); end
      for (int k = 0; k < 4; k++) begin
         nn = 16'(k + 1);
         checks++;
         if (q0 + k >= q_pairs.size()) begin
            errors++; $display("FAIL ovr_drain%0d got none want %h", k, {nn, ~nn});
         end else if (q_pairs[q0+k] !== {nn, ~nn}) begin
            errors++; $display("FAIL ovr_drain%0d got %h want %h", k, q_pairs[q0+k], {nn, ~nn});
         end
      end
      checks++; if (din_rts !== 1'b0) begin errors++; $display("FAIL ovr_rts_drained got %b want 0", din_rts); end
      checks++; if ({din_lft, din_rgt} !== 32'h0004_FFFB) begin errors++; $display("FAIL ovr_hold_last got %h want 0004fffb", {din_lft, din_rgt}); end
      checks++; if (fifo_overun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", fifo_overun); end
      do_reset();
      checks++; if (fifo_overun !== 1'b0) begin errors++; $display("FAIL ovr_cleared got %b want 0", fifo_overun); end
   endtask

   task automatic test_full_pop();
      int q0;
      logic [15:0] nn;
      do_reset();
      set_rtr(1'b0);
      q0 = q_pairs.size();
      preamble();
      for (int n = 1; n <= 5; n++) begin
         nn = 16'(n);
         send_frame({16'h0, nn}, {16'h0, ~nn}, 16);
      end
      // Closing edge of frame 5, with rtr high exactly in the push cycle.
      sck = 1'b0;
      ws  = 1'b0;
      sd  = tb_pend;
      repeat (4) @(negedge clk);
      sck = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 din_rtr = 1'b1;
      @(posedge clk);
      #1 din_rtr = 1'b0;
      repeat (12) @(negedge clk);
      checks++; if (fifo_overun !== 1'b0) begin errors++; $display("FAIL fpop_overun got %b want 0", fifo_overun); end
      set_rtr(1'b1);
      repeat (10) @(negedge clk);
      checks++; if (q_pairs.size() - q0 !== 5) begin errors++; $display("FAIL fpop_count got %0d want 5", q_pairs.size() - q0); end
      for (int k = 0; k < 5; k++) begin
         nn = 16'(k + 1);
         checks++;
         if (q0 + k >= q_pairs.size()) begin
            errors++; $display("FAIL fpop_pair%0d got none want %h", k, {nn, ~nn});
         end else if (q_pairs[q0+k] !== {nn, ~nn}) begin
            errors++; $display("FAIL fpop_pair%0d got %h want %h", k, q_pairs[q0+k], {nn, ~nn});
         end
      end
   endtask

   task automatic test_reset_mid();
      int q0;
      do_reset();
      set_rtr(1'b0);
      preamble();
      send_frame(32'h1111, 32'h2222, 16);
      send_slot(1'b0, 32'h3333, 16, 0, 7);
      checks++; if (din_rts !== 1'b1) begin errors++; $display("FAIL rmid_rts_before got %b want 1", din_rts); end
      rst = 1'b1;
      send_slot(1'b0, 32'h3333, 16, 7, 10);
      checks++; if ({din_lft, din_rgt} !== 32'h0) begin errors++; $display("FAIL rmid_data_in_reset got %h want 00000000", {din_lft, din_rgt}); end
      checks++; if (din_rts !== 1'b0) begin errors++; $display("FAIL rmid_rts_in_reset got %b want 0", din_rts); end
      rst = 1'b0;
      send_slot(1'b0, 32'h3333, 16, 10, 16);
      send_slot(1'b1, 32'h4444, 16, 0, 16);
      set_rtr(1'b1);
      q0 = q_pairs.size();
      send_frame(32'h5555, 32'h6666, 16);
      close_frame();
      checks++; if (q_pairs.size() - q0 !== 1) begin errors++; $display("FAIL rmid_count got %0d want 1", q_pairs.size() - q0); end
      checks++;
      if (q0 >= q_pairs.size()) begin
         errors++; $display("FAIL rmid_pair got none want 55556666");
      end else if (q_pairs[q0] !== 32'h5555_6666) begin
         errors++; $display("FAIL rmid_pair got %h want 55556666", q_pairs[q0]);
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      rts_cycles = 0;
      tb_pend    = 1'b0;
      test_reset();
      test_basic();
      test_mid_slot();
      test_widths();
      test_overrun();
      test_full_pop();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
